// File: rtl/fir_tap_reader_pkg.sv
// Shared definitions for the FIR_LPF sample path: default datapath sizes
// (shared with the coefficient ROM and MAC) and the tap-reader state encoding.
package fir_tap_reader_pkg;

    localparam int DW_DEF   = 16;
    localparam int TAPS_DEF = 64;
    localparam int AW_DEF   = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fir_dline_ram.sv
// Simple dual-port delay-line RAM: one write port, one registered read port.
// No reset on the storage so synthesis maps it onto block RAM.
module fir_dline_ram #(
    parameter int DW   = 16,
    parameter int TAPS = 64,
    parameter int AW   = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [TAPS];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fir_tap_reader.sv
// Delay-line writer/reader for the FIR_LPF: on each synchronised s_clk rise,
// stores one sample then streams all taps newest-to-oldest to the MAC stage.
module fir_tap_reader
    import fir_tap_reader_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [AW-1:0] coef_addr,
    output logic [DW-1:0] smp,
    output logic          smp_vld,
    output logic          smp_last,
    output logic          busy,
    output logic          ovr
);

    localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(TAPS);

    logic          pl0_reg;
    logic          pl1_reg;
    logic          s_edge;

    logic [1:0]    state_reg,  state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] k_reg,      k_next;
    logic [AW:0]   fill_reg,   fill_next;

    logic          vld_reg;
    logic          last_reg;
    logic          mask_reg;
    logic [AW-1:0] addr_reg;
    logic          ovr_reg;

    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl0_reg <= 1'b0;
            pl1_reg <= 1'b0;
        end else begin
            pl0_reg <= s_clk;
            pl1_reg <= pl0_reg;
        end
    end

    assign s_edge = pl0_reg & ~pl1_reg;

    // Writes happen only in IDLE, so the read port never sees a same-address collision.
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        k_next      = k_reg;
        fill_next   = fill_reg;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s_edge && en) begin
                    ram_we      = 1'b1;
                    rd_ptr_next = wr_ptr_reg;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    fill_next   = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;
                    k_next      = '0;
                    state_next  = ST_READ;
                end
            end
            ST_READ: begin
                ram_re      = 1'b1;
                rd_ptr_next = rd_ptr_reg - 1'b1;
                k_next      = k_reg + 1'b1;
                if (k_reg == K_LAST) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            k_reg      <= '0;
            fill_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            k_reg      <= k_next;
            fill_reg   <= fill_next;
        end
    end

    // Output qualifiers are delayed one cycle to line up with the registered RAM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
            mask_reg <= 1'b0;
            addr_reg <= '0;
            ovr_reg  <= 1'b0;
        end else begin
            vld_reg  <= (state_reg == ST_READ);
            last_reg <= (state_reg == ST_READ) && (k_reg == K_LAST);
            mask_reg <= ({1'b0, k_reg} >= fill_reg);
            addr_reg <= k_reg;
            ovr_reg  <= s_edge && (state_reg != ST_IDLE);
        end
    end

    fir_dline_ram #(
        .DW   (DW),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_dline (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    // Slots beyond fill were never written since reset and must read as zero.
    assign smp       = (vld_reg && !mask_reg) ? ram_rdata : '0;
    assign smp_vld   = vld_reg;
    assign smp_last  = last_reg;
    assign coef_addr = addr_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign ovr       = ovr_reg;

endmodule

// File: tb/tb_fir_tap_reader.sv
// Scoreboard bench for fir_tap_reader: each accepted sample edge pushes the
// 64 expected tap beats; a negedge monitor pops and compares them.
module tb_fir_tap_reader;

    localparam int DW   = 16;
    localparam int TAPS = 64;
    localparam int AW   = 6;
    localparam int SEQ_SPAN = TAPS + 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] smp;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          s_clk;
    logic          en;
    logic [DW-1:0] din;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] smp;
    logic          smp_vld;
    logic          smp_last;
    logic          busy;
    logic          ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] model_mem [TAPS];
    int model_wr = 0;
    int model_fill = 0;
    int last_acc = -1000;
    int acc_cnt = 0;
    int exp_ovr = 0;
    int busy_cnt = 0;
    int ovr_cnt = 0;
    beat_t exp_q[$];
    beat_t mon_b;

    fir_tap_reader #(
        .DW   (DW),
        .TAPS (TAPS),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_clk     (s_clk),
        .en        (en),
        .din       (din),
        .coef_addr (coef_addr),
        .smp       (smp),
        .smp_vld   (smp_vld),
        .smp_last  (smp_last),
        .busy      (busy),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy) busy_cnt++;
            if (ovr) ovr_cnt++;
            if (smp_vld) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_vld", 32'd1, 32'd0);
                end else begin
                    mon_b = exp_q.pop_front();
                    check_val("coef_addr", 32'(coef_addr), 32'(mon_b.addr));
                    check_val("smp", 32'(smp), 32'(mon_b.smp));
                    check_val("smp_last", 32'(smp_last), 32'(mon_b.last));
                end
            end
        end
    end

    task automatic push_seq(input logic [DW-1:0] d);
        int w;
        beat_t b;
        w = model_wr;
        model_mem[w] = d;
        model_wr = (model_wr + 1) % TAPS;
        if (model_fill < TAPS) model_fill++;
        for (int k = 0; k < TAPS; k++) begin
            b.addr = AW'(k);
            b.smp  = (k < model_fill) ? model_mem[(w - k + TAPS) % TAPS] : '0;
            b.last = (k == TAPS - 1);
            exp_q.push_back(b);
        end
    endtask

    // Rises s_clk just after a clk edge, so acceptance depends only on cycle spacing.
    task automatic sample_edge(input logic [DW-1:0] d, input logic e, input int hi, input int lo);
        string what;
        @(posedge clk);
        #1;
        din = d;
        en = e;
        s_clk = 1'b1;
        if (cyc - last_acc >= SEQ_SPAN) begin
            if (e) begin
                last_acc = cyc;
                acc_cnt++;
                push_seq(d);
                what = "accepted";
            end else begin
                what = "ignored";
            end
        end else begin
            exp_ovr++;
            what = "dropped";
        end
        $display("edge cyc=%0d din=0x%h en=%0d %s", cyc, d, e, what);
        repeat (hi) @(posedge clk);
        #1 s_clk = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic clear_model();
        model_wr = 0;
        model_fill = 0;
        last_acc = -1000;
        acc_cnt = 0;
        exp_ovr = 0;
        busy_cnt = 0;
        ovr_cnt = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_vld", 32'(smp_vld), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
    endtask

    task automatic phase_check(input string tag);
        repeat (SEQ_SPAN + 10) @(posedge clk);
        check_val({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(acc_cnt * (TAPS + 1)));
        check_val({tag, "_ovr_pulses"}, 32'(ovr_cnt), 32'(exp_ovr));
        $display("phase %s accepted=%0d ovr=%0d", tag, acc_cnt, ovr_cnt);
        acc_cnt = 0;
        exp_ovr = 0;
        busy_cnt = 0;
        ovr_cnt = 0;
    endtask

    initial begin
        int t;
        bit found;
        for (int i = 0; i < TAPS; i++) model_mem[i] = '0;
        rst = 1'b0;
        s_clk = 1'b0;
        en = 1'b0;
        din = '0;
        #1;
        check_val("reset_smp_vld", 32'(smp_vld), 32'd0);
        check_val("reset_smp", 32'(smp), 32'd0);
        check_val("reset_coef_addr", 32'(coef_addr), 32'd0);
        check_val("reset_smp_last", 32'(smp_last), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_ovr", 32'(ovr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        sample_edge(16'h1234, 1'b1, 35, 35);
        phase_check("single");

        do_reset();
        for (int n = 1; n <= 3; n++) sample_edge(DW'(n), 1'b1, 35, 35);
        phase_check("three");

        do_reset();
        for (int n = 1; n <= 70; n++) sample_edge(DW'(n), 1'b1, 35, 35);
        phase_check("wrap70");

        sample_edge(16'hBEEF, 1'b0, 35, 35);
        sample_edge(16'h0042, 1'b1, 35, 35);
        phase_check("en_low");

        for (int i = 0; i < 12; i++) sample_edge(DW'(16'h0100 + i), 1'b1, 10, 9);
        phase_check("fast_sclk");

        sample_edge(16'h0A0A, 1'b1, 33, 32);
        sample_edge(16'h0B0B, 1'b1, 32, 32);
        sample_edge(16'h0C0C, 1'b0, 33, 32);
        sample_edge(16'h0D0D, 1'b1, 40, 40);
        phase_check("drain_edge");

        sample_edge(16'hAAAA, 1'b1, 5, 0);
        found = 1'b0;
        t = 0;
        while (!found && t < 200) begin
            @(posedge clk);
            #2;
            if (smp_vld && coef_addr == AW'(30)) found = 1'b1;
            t++;
        end
        check_val("k30_reached", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check_val("abort_smp_vld", 32'(smp_vld), 32'd0);
        check_val("abort_smp", 32'(smp), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_coef_addr", 32'(coef_addr), 32'd0);
        check_val("abort_smp_last", 32'(smp_last), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sample_edge(16'h0055, 1'b1, 35, 35);
        phase_check("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
